// File: rtl/alu_pipe_if.sv
// Request/response bundle for alu_pipe.
// slave  : the ALU pipeline side (accepts requests, produces responses).
// master : the issuing/consuming side.
interface alu_pipe_if #(
    parameter int XLEN               = 64,
    parameter int ROB_INDEX_WIDTH    = 6,
    parameter int PHY_REG_ADDR_WIDTH = 6,
    parameter int VIRTUAL_ADDR_LEN   = 39,
    parameter int RESP_DEPTH         = 2
);
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);

    // Pipeline control
    logic                          flush_i;

    // Request channel
    logic                          req_valid_i;
    logic                          req_ready_o;
    logic [XLEN-1:0]               opr1_i;
    logic [XLEN-1:0]               opr2_i;
    logic                          half_i;
    logic [2:0]                    func_i;
    logic                          modifier_i;
    logic [XLEN-1:0]               cmp_a_i;
    logic [XLEN-1:0]               cmp_b_i;
    logic [2:0]                    cmp_func_i;
    logic                          is_jump_i;
    logic                          is_branch_i;
    logic [VIRTUAL_ADDR_LEN-1:0]   pc_i;
    logic [VIRTUAL_ADDR_LEN-1:0]   next_pc_i;
    logic [ROB_INDEX_WIDTH-1:0]    rob_index_i;
    logic [PHY_REG_ADDR_WIDTH-1:0] prd_addr_i;

    // Response channel
    logic                          resp_valid_o;
    logic                          resp_ready_i;
    logic [XLEN-1:0]               alu_result_o;
    logic                          cmp_result_o;
    logic                          is_jump_o;
    logic                          is_branch_o;
    logic [VIRTUAL_ADDR_LEN-1:0]   pc_o;
    logic [VIRTUAL_ADDR_LEN-1:0]   next_pc_o;
    logic [ROB_INDEX_WIDTH-1:0]    rob_index_o;
    logic [PHY_REG_ADDR_WIDTH-1:0] prd_addr_o;
    logic [CNT_W-1:0]              resp_count_o;

    modport slave (
        input  flush_i,
        input  req_valid_i, opr1_i, opr2_i, half_i, func_i, modifier_i,
        input  cmp_a_i, cmp_b_i, cmp_func_i, is_jump_i, is_branch_i,
        input  pc_i, next_pc_i, rob_index_i, prd_addr_i,
        output req_ready_o,
        input  resp_ready_i,
        output resp_valid_o, alu_result_o, cmp_result_o, is_jump_o, is_branch_o,
        output pc_o, next_pc_o, rob_index_o, prd_addr_o, resp_count_o
    );

    modport master (
        output flush_i,
        output req_valid_i, opr1_i, opr2_i, half_i, func_i, modifier_i,
        output cmp_a_i, cmp_b_i, cmp_func_i, is_jump_i, is_branch_i,
        output pc_i, next_pc_i, rob_index_i, prd_addr_i,
        input  req_ready_o,
        output resp_ready_i,
        input  resp_valid_o, alu_result_o, cmp_result_o, is_jump_o, is_branch_o,
        input  pc_o, next_pc_o, rob_index_o, prd_addr_o, resp_count_o
    );
endinterface

// File: rtl/alu_pipe.sv
// Single-cycle integer ALU + branch comparator feeding a small circular
// response FIFO. A request is computed combinationally and written into the
// FIFO at the accepting edge; the FIFO head drives the response outputs.
// req_ready_o depends only on flush_i and the registered occupancy, so the
// consumer's resp_ready_i never reaches it combinationally.
module alu_pipe #(
    parameter int XLEN               = 64,
    parameter int ROB_INDEX_WIDTH    = 6,
    parameter int PHY_REG_ADDR_WIDTH = 6,
    parameter int VIRTUAL_ADDR_LEN   = 39,
    parameter int RESP_DEPTH         = 2
) (
    input  logic      clk,
    input  logic      rst,
    alu_pipe_if.slave bus
);
    localparam int SHAMT_W = $clog2(XLEN);
    localparam int PTR_W   = $clog2(RESP_DEPTH);
    localparam int CNT_W   = $clog2(RESP_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(RESP_DEPTH);

    typedef enum logic [2:0] {
        FN_ADD  = 3'd0,
        FN_SLL  = 3'd1,
        FN_SLT  = 3'd2,
        FN_SLTU = 3'd3,
        FN_XOR  = 3'd4,
        FN_SRL  = 3'd5,
        FN_OR   = 3'd6,
        FN_AND  = 3'd7
    } alu_func_e;

    typedef struct packed {
        logic [XLEN-1:0]               alu_result;
        logic                          cmp_result;
        logic                          is_jump;
        logic                          is_branch;
        logic [VIRTUAL_ADDR_LEN-1:0]   pc;
        logic [VIRTUAL_ADDR_LEN-1:0]   next_pc;
        logic [ROB_INDEX_WIDTH-1:0]    rob_index;
        logic [PHY_REG_ADDR_WIDTH-1:0] prd_addr;
    } resp_entry_t;

    // Reject unsupported configurations at elaboration time.
    if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
        $error("alu_pipe: XLEN must be 32 or 64");
    end
    if (RESP_DEPTH < 2 || (RESP_DEPTH & (RESP_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("alu_pipe: RESP_DEPTH must be a power of two and at least 2");
    end

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [SHAMT_W-1:0] w_shamt;
    logic [4:0]         w_shamt_word;
    logic               w_lt_signed;
    logic               w_lt_unsigned;
    logic               w_word_op;
    logic [31:0]        w_word_result;
    logic [63:0]        w_word_sext;
    logic [XLEN-1:0]    w_full_result;
    logic [XLEN-1:0]    w_alu_result;

    // Compute the full-width result and the 32-bit W-form result, then pick.
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_shamt       = bus.opr2_i[SHAMT_W-1:0];
        w_shamt_word  = bus.opr2_i[4:0];
        w_lt_signed   = $signed(bus.opr1_i) < $signed(bus.opr2_i);
        w_lt_unsigned = bus.opr1_i < bus.opr2_i;
        w_word_result = '0;
        w_full_result = '0;
        w_word_op     = 1'b0;

        case (alu_func_e'(bus.func_i))
            FN_ADD: begin
                w_word_op = 1'b1;
                if (bus.modifier_i) begin
                    w_word_result = bus.opr1_i[31:0] - bus.opr2_i[31:0];
                    w_full_result = bus.opr1_i - bus.opr2_i;
                end else begin
                    w_word_result = bus.opr1_i[31:0] + bus.opr2_i[31:0];
                    w_full_result = bus.opr1_i + bus.opr2_i;
                end
            end
            FN_SLL: begin
                w_word_op     = 1'b1;
                w_word_result = bus.opr1_i[31:0] << w_shamt_word;
                w_full_result = bus.opr1_i << w_shamt;
            end
            FN_SLT:  w_full_result = XLEN'(w_lt_signed);
            FN_SLTU: w_full_result = XLEN'(w_lt_unsigned);
            FN_XOR:  w_full_result = bus.opr1_i ^ bus.opr2_i;
            FN_SRL: begin
                w_word_op = 1'b1;
                // NOTE: the arithmetic and logical shifts sit in separate
                // branches; inside one ?: the unsigned arm would make the
                // whole expression unsigned and turn >>> into a logical shift.
                if (bus.modifier_i) begin
                    w_word_result = $signed(bus.opr1_i[31:0]) >>> w_shamt_word;
                    w_full_result = $signed(bus.opr1_i) >>> w_shamt;
                end else begin
                    w_word_result = bus.opr1_i[31:0] >> w_shamt_word;
                    w_full_result = bus.opr1_i >> w_shamt;
                end
            end
            FN_OR:   w_full_result = bus.opr1_i | bus.opr2_i;
            FN_AND: begin
                if (bus.modifier_i) begin
                    w_full_result = (~bus.opr1_i) & bus.opr2_i;
                end else begin
                    w_full_result = bus.opr1_i & bus.opr2_i;
                end
            end
            default: w_full_result = '0;
        endcase

        // W-form only exists on a 64-bit datapath, and only for add/sub/shifts.
        w_word_sext  = {{32{w_word_result[31]}}, w_word_result};
        w_alu_result = w_full_result;
        if ((XLEN == 64) && bus.half_i && w_word_op) begin
            w_alu_result = w_word_sext[XLEN-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Branch comparator
    // ------------------------------------------------------------------
    logic w_cmp_eq;
    logic w_cmp_lt;
    logic w_cmp_result;

    // bit2: less-than vs equal, bit1: unsigned, bit0: invert.
    always_comb begin
        w_cmp_eq = (bus.cmp_a_i == bus.cmp_b_i);
        if (bus.cmp_func_i[1]) begin
            w_cmp_lt = bus.cmp_a_i < bus.cmp_b_i;
        end else begin
            w_cmp_lt = $signed(bus.cmp_a_i) < $signed(bus.cmp_b_i);
        end
        w_cmp_result = (bus.cmp_func_i[2] ? w_cmp_lt : w_cmp_eq) ^ bus.cmp_func_i[0];
    end

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    resp_entry_t      r_mem [RESP_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic [PTR_W-1:0] w_wr_ptr_next;
    logic [PTR_W-1:0] w_rd_ptr_next;
    logic [CNT_W-1:0] w_count_next;
    logic             w_push;
    logic             w_pop;
    resp_entry_t      w_entry;
    resp_entry_t      w_head;

    assign bus.req_ready_o = !bus.flush_i && (r_count < FULL_COUNT);
    assign w_push          = bus.req_valid_i && bus.req_ready_o;
    assign w_pop           = bus.resp_valid_o && bus.resp_ready_i && !bus.flush_i;

    assign w_entry.alu_result = w_alu_result;
    assign w_entry.cmp_result = w_cmp_result;
    assign w_entry.is_jump    = bus.is_jump_i;
    assign w_entry.is_branch  = bus.is_branch_i;
    assign w_entry.pc         = bus.pc_i;
    assign w_entry.next_pc    = bus.next_pc_i;
    assign w_entry.rob_index  = bus.rob_index_i;
    assign w_entry.prd_addr   = bus.prd_addr_i;

    // Next pointers/occupancy; flush wins over any push or pop this cycle.
    always_comb begin
        w_wr_ptr_next = r_wr_ptr;
        w_rd_ptr_next = r_rd_ptr;
        w_count_next  = r_count;
        if (bus.flush_i) begin
            w_wr_ptr_next = '0;
            w_rd_ptr_next = '0;
            w_count_next  = '0;
        end else begin
            if (w_push) begin
                w_wr_ptr_next = r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                w_rd_ptr_next = r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                w_count_next = r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                w_count_next = r_count - CNT_W'(1);
            end
        end
    end

    // Pointer and occupancy registers with asynchronous reset.
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_next;
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= w_count_next;
        end
    end

    // Entry storage: written on accept, read at the head pointer.
    // NOTE: the storage array has no reset; an entry is only ever observed
    // after a push has written it, because occupancy gates resp_valid_o.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    assign bus.resp_valid_o = (r_count != '0);
    assign bus.resp_count_o = r_count;
    assign bus.alu_result_o = w_head.alu_result;
    assign bus.cmp_result_o = w_head.cmp_result;
    assign bus.is_jump_o    = w_head.is_jump;
    assign bus.is_branch_o  = w_head.is_branch;
    assign bus.pc_o         = w_head.pc;
    assign bus.next_pc_o    = w_head.next_pc;
    assign bus.rob_index_o  = w_head.rob_index;
    assign bus.prd_addr_o   = w_head.prd_addr;
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- XLEN, 64, datapath width; 32 or 64 only.
- ROB_INDEX_WIDTH, 6, ROB tag width.
- PHY_REG_ADDR_WIDTH, 6, physical destination register width.
- VIRTUAL_ADDR_LEN, 39, PC width.
- RESP_DEPTH, 2, response buffer entries; power of two, at least 2.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock.
- rst, in, 1, asynchronous active-high reset.
- flush_i, in, 1, kill everything in flight.
- req_valid_i, in, 1, request valid.
- req_ready_o, out, 1, request accepted when high together with req_valid_i.
- opr1_i and opr2_i, in, XLEN, operands.
- half_i, in, 1, 32-bit W-form operation.
- func_i, in, 3, ALU function.
- modifier_i, in, 1, sub/sra/clr modifier.
- cmp_a_i and cmp_b_i, in, XLEN, compare operands.
- cmp_func_i, in, 3, compare function.
- is_jump_i and is_branch_i, in, 1 each.
- pc_i and next_pc_i, in, VIRTUAL_ADDR_LEN.
- rob_index_i, in, ROB_INDEX_WIDTH.
- prd_addr_i, in, PHY_REG_ADDR_WIDTH.
- resp_valid_o, out, 1, response valid.
- resp_ready_i, in, 1, consumer accepts the response.
- alu_result_o, out, XLEN.
- cmp_result_o, is_jump_o, is_branch_o, out, 1 each.
- pc_o and next_pc_o, out, VIRTUAL_ADDR_LEN.
- rob_index_o, out, ROB_INDEX_WIDTH.
- prd_addr_o, out, PHY_REG_ADDR_WIDTH.
- resp_count_o, out, clog2(RESP_DEPTH+1), occupied entries.

Function
REQ-003 func_i encoding SHALL be:
- 0 ADD/SUB: subtract when modifier_i=1.
- 1 SLL.
- 2 SLT and 3 SLTU: result is the zero-extended 1-bit result.
- 4 XOR.
- 5 SRL/SRA: arithmetic when modifier_i=1.
- 6 OR.
- 7 AND/CLR: result is (~opr1_i) & opr2_i when modifier_i=1.

REQ-004 Full-width shift amount SHALL be opr2_i[clog2(XLEN)-1:0].

REQ-005 When XLEN=64 and half_i=1:
- ADD/SUB, SLL and SRL/SRA SHALL operate on bits [31:0] with shift amount opr2_i[4:0].
- The 32-bit result SHALL be sign-extended from bit 31.
- SRA fills with opr1_i[31]; SRL fills with 0.
- half_i SHALL be ignored for other functions, and ignored entirely when XLEN=32.

REQ-006 Compare SHALL use cmp_func_i bits as follows:
- Bit2 selects less-than (1) or equal (0).
- Bit1 selects unsigned comparison.
- Bit0 inverts the result.

REQ-007 Responses SHALL be held in a circular FIFO of RESP_DEPTH entries with read and write pointers that wrap modulo RESP_DEPTH.

REQ-008 req_ready_o SHALL equal !flush_i && (count < RESP_DEPTH), and SHALL have no combinational path from resp_ready_i.

REQ-009 On an accept (req_valid_i && req_ready_o), the computed result and all sideband fields SHALL be written to the FIFO at the clock edge.
- is_jump_o and is_branch_o SHALL be stored as is_jump_i and is_branch_i.
- Latency SHALL be exactly one cycle when the FIFO was empty.

REQ-010 resp_valid_o SHALL equal (count != 0); all response outputs SHALL present the head entry.

REQ-011 A pop SHALL occur when resp_valid_o && resp_ready_i. A simultaneous push and pop SHALL leave count unchanged and keep ordering.

REQ-012 Responses SHALL leave in strict acceptance order, and each response SHALL be delivered exactly once.

REQ-013 Output fields SHALL hold stable while resp_valid_o=1 and resp_ready_i=0.

REQ-014 flush_i=1 at a clock edge SHALL:
- Zero count and both pointers.
- Discard any pop in the same cycle.
- Block any push in the same cycle.
- Leave resp_valid_o=0 in the following cycle.

REQ-015 When resp_valid_o=0, output data fields SHALL be don't-care.

Reset
REQ-016 While rst=1, asynchronously:
- Count and both pointers SHALL be zero.
- resp_valid_o and resp_count_o SHALL be 0.
- req_ready_o SHALL be 1 whenever flush_i=0.
- Stored entries SHALL not need to be reset.

REQ-017 rst asserted mid-operation SHALL discard all buffered responses. The first edge after deassertion SHALL be able to accept a request.

Verification
REQ-018 The bench SHALL use XLEN=64, RESP_DEPTH=2 and cover these directed scenarios:
- ADDW: opr1=0x7FFFFFFF, opr2=1, half=1, func=0 -> one cycle later resp_valid_o=1, alu_result_o=0xFFFFFFFF80000000.
- SRA/SRAW: opr1=0x8000000000000000, opr2=63, func=5, modifier=1 -> alu_result_o=0xFFFFFFFFFFFFFFFF. With opr1=0x80000000, opr2=4, half=1 -> alu_result_o=0xFFFFFFFFF8000000.
- SLT/SLTU and compare: opr1=0xFFFFFFFFFFFFFFFF, opr2=1 -> SLT gives 1, SLTU gives 0. cmp_a=cmp_b=5 with cmp_func=3'b001 -> cmp_result_o=0.
- Backpressure: resp_ready_i=0, three back-to-back requests with rob_index 1, 2, 3 -> two accepted, req_ready_o=0, resp_count_o=2, head stays rob 1. Raising resp_ready_i pops rob 1 then 2, then rob 3 is accepted and delivered in order.
- Flush: two entries buffered, flush_i=1 for one cycle with req_valid_i=1 -> req_ready_o=0 that cycle, next cycle resp_count_o=0 and resp_valid_o=0, and no response for the flushed request ever appears.
- Reset mid-operation: one entry buffered, rst pulsed asynchronously between edges -> resp_valid_o drops immediately, and after release a new ADD 2+3 returns 5 one cycle after acceptance.
